bt_rnd_bank: RTL and testbench
==============================

BT_RND_BANK -- requirements
Module: bt_rnd_bank

Interface
REQ-001 SHALL have parameter N_BITS, default 40, meaning the number of accumulated fresh-randomness bits, one per masked register.
REQ-002 SHALL have parameter RND_W, default 4, meaning bits accepted per handshake; N_BITS mod RND_W = 0 is required and is checked at elaboration.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port rnd_in, input, RND_W bits: a fresh randomness word.
REQ-006 SHALL have port rnd_valid, input, 1 bit: rnd_in is valid.
REQ-007 SHALL have port rnd_ready, output, 1 bit: the bank accepts rnd_in this cycle.
REQ-008 SHALL have port clear, input, 1 bit: level request; only its rising edge acts.
REQ-009 SHALL have port rnd_acc, output, N_BITS bits: accumulated randomness, one bit per masked register.
REQ-010 SHALL have port fresh_clear, output, N_BITS bits: per-register clear strobe.
REQ-011 SHALL have port armed, output, 1 bit: all N_BITS bits are fresh.
REQ-012 SHALL have port fill_cnt, output, clog2(N_BITS/RND_W+1) bits: number of fresh words.
REQ-013 SHALL have port partial_clr, output, 1 bit: sticky flag, a clear edge arrived while not armed.
REQ-014 SHALL have port clr_count, output, 16 bits: count of clear edges, wraps from 0xFFFF to 0.

Function
REQ-015 SHALL compute clear_pulse = clear & ~clear_d, where clear_d is clear registered by one cycle.
REQ-016 SHALL implement states EMPTY (fill_cnt=0), FILLING (0<fill_cnt<N_BITS/RND_W) and ARMED (fill_cnt=N_BITS/RND_W).
REQ-017 SHALL drive rnd_ready = (state != ARMED) & ~clear_pulse, combinationally.
REQ-018 SHALL, on a handshake (rnd_valid & rnd_ready), update rnd_acc <= {rnd_acc[N_BITS-RND_W-1:0], rnd_in} and increment fill_cnt by 1.
REQ-019 SHALL hold rnd_acc and fill_cnt unchanged in any cycle without a handshake; no shifting while ARMED.
REQ-020 SHALL define the unused mask combinationally: bit i = 1 iff i < fill_cnt*RND_W.
REQ-021 SHALL drive fresh_clear = unused mask & {N_BITS{clear_pulse}}, combinationally in the pulse cycle, zero otherwise.
REQ-022 SHALL, on clear_pulse, set fill_cnt <= 0 (enter EMPTY) and increment clr_count, while rnd_acc holds its value.
REQ-023 SHALL set partial_clr <= 1 on a clear_pulse with state != ARMED; it clears only on rst.
REQ-024 SHALL treat clear held high as a single event; a new event needs clear low for at least one cycle.
REQ-025 SHALL make fill_cnt saturate-free: it never exceeds N_BITS/RND_W because rnd_ready is low in ARMED.
REQ-026 SHALL drive armed = (state == ARMED), registered-state derived, with no combinational input path.

Reset
REQ-027 SHALL, on rst, set rnd_acc=0, fill_cnt=0 (EMPTY), partial_clr=0, clr_count=0 and clear_d=1, so that a clear held high through reset produces no pulse.
REQ-028 SHALL give rst priority over a simultaneous handshake and clear_pulse; outputs become valid reset values in the following cycle.
REQ-029 SHALL, when rst is asserted mid-fill, discard all fill progress; refilling restarts from EMPTY.

Structure
REQ-030 SHALL place the state enum (EMPTY/FILLING/ARMED) and the default N_BITS/RND_W constants in shared package bt_pkg.
REQ-031 SHALL implement the rising-edge detector (clear_d register with its reset value) as sub-module bt_edge_det, which is reused by the other BT blocks.

Verification (N_BITS=40, RND_W=4)
REQ-032 SHALL verify fill: after rst, 10 handshakes with rnd_in=0x1..0xA give armed=1, rnd_acc=0x123456789A and fill_cnt=10; an 11th rnd_valid sees rnd_ready=0 and rnd_acc is unchanged.
REQ-033 SHALL verify armed clear: clear rising while ARMED gives fresh_clear=0xFFFFFFFFFF for exactly one cycle, then fill_cnt=0, clr_count=1 and partial_clr=0.
REQ-034 SHALL verify partial clear: 3 handshakes then a clear edge give fresh_clear=0x0000000FFF for one cycle and partial_clr=1, which stays 1 after a later full refill.
REQ-035 SHALL verify simultaneous events: rnd_valid=1 in the clear_pulse cycle gives rnd_ready=0, no shift, fill_cnt=0 next cycle, and acceptance resumes the cycle after.
REQ-036 SHALL verify held clear: clear high for 20 cycles gives one pulse (clr_count +1); clear high across rst deassertion gives no pulse and clr_count=0.
REQ-037 SHALL verify reset mid-fill: rst after 5 handshakes gives rnd_acc=0 and fill_cnt=0, and a subsequent 10 handshakes re-arm the bank.

Source files
------------

// File: rtl/bt_pkg.sv
// Shared definitions for the BT randomness blocks: bank states and default sizing.
package bt_pkg;

  localparam int unsigned BT_N_BITS = 40;
  localparam int unsigned BT_RND_W  = 4;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    ARMED   = 2'd2
  } bt_state_e;

endpackage

// File: rtl/bt_edge_det.sv
// Rising-edge detector with a configurable reset value for the delayed sample.
module bt_edge_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_pulse_c
);

  logic r_sig_d;

  always_ff @(posedge clk) begin
    if (rst) r_sig_d <= RST_VAL;
    else     r_sig_d <= i_sig;
  end

  assign o_pulse_c = i_sig & ~r_sig_d;

endmodule

// File: rtl/bt_rnd_bank.sv
// Fresh-randomness bank: shifts in RND_W-bit words until N_BITS are fresh,
// and on a clear edge strobes the consumed bits and restarts the fill.
module bt_rnd_bank
  import bt_pkg::*;
#(
  parameter int unsigned N_BITS = BT_N_BITS,
  parameter int unsigned RND_W  = BT_RND_W
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [RND_W-1:0]                     rnd_in,
  input  logic                                 rnd_valid,
  output logic                                 rnd_ready,
  input  logic                                 clear,
  output logic [N_BITS-1:0]                    rnd_acc,
  output logic [N_BITS-1:0]                    fresh_clear,
  output logic                                 armed,
  output logic [$clog2(N_BITS/RND_W+1)-1:0]    fill_cnt,
  output logic                                 partial_clr,
  output logic [15:0]                          clr_count
);

  localparam int unsigned N_WORDS = N_BITS / RND_W;
  localparam int unsigned CNT_W   = $clog2(N_WORDS + 1);

  if ((N_BITS % RND_W) != 0) begin : g_bad_size
    $error("bt_rnd_bank: N_BITS must be a multiple of RND_W");
  end

  bt_state_e         r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_fill_cnt, w_fill_nxt;
  logic [N_BITS-1:0] r_acc, w_acc_nxt, w_shift, w_unused;
  logic              r_partial, w_partial_nxt;
  logic [15:0]       r_clr_count, w_clr_nxt;
  logic              w_clr_pulse, w_hs;
  logic [31:0]       w_used_bits;

  bt_edge_det #(.RST_VAL(1'b1)) u_clr_edge (
    .clk       (clk),
    .rst       (rst),
    .i_sig     (clear),
    .o_pulse_c (w_clr_pulse)
  );

  // Single-word banks have no history to keep.
  if (N_WORDS == 1) begin : g_single
    assign w_shift = rnd_in;
  end else begin : g_shift
    assign w_shift = {r_acc[N_BITS-RND_W-1:0], rnd_in};
  end

  assign rnd_ready   = (r_state != ARMED) & ~w_clr_pulse;
  assign w_hs        = rnd_valid & rnd_ready;
  assign w_used_bits = 32'(r_fill_cnt) * 32'(RND_W);
  assign w_unused    = ~({N_BITS{1'b1}} << w_used_bits);
  assign fresh_clear = w_unused & {N_BITS{w_clr_pulse}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_fill_cnt  <= '0;
      r_acc       <= '0;
      r_partial   <= 1'b0;
      r_clr_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_fill_cnt  <= w_fill_nxt;
      r_acc       <= w_acc_nxt;
      r_partial   <= w_partial_nxt;
      r_clr_count <= w_clr_nxt;
    end
  end

  // Clear edge wins over fill; a handshake cannot coincide with it since ready drops.
  always_comb begin
    w_state_nxt   = r_state;
    w_fill_nxt    = r_fill_cnt;
    w_acc_nxt     = r_acc;
    w_partial_nxt = r_partial;
    w_clr_nxt     = r_clr_count;
    if (w_clr_pulse) begin
      w_state_nxt = EMPTY;
      w_fill_nxt  = '0;
      w_clr_nxt   = r_clr_count + 16'd1;
      if (r_state != ARMED) w_partial_nxt = 1'b1;
    end else if (w_hs) begin
      w_acc_nxt   = w_shift;
      w_fill_nxt  = r_fill_cnt + CNT_W'(1);
      w_state_nxt = (w_fill_nxt == CNT_W'(N_WORDS)) ? ARMED : FILLING;
    end
  end

  assign rnd_acc     = r_acc;
  assign fill_cnt    = r_fill_cnt;
  assign armed       = (r_state == ARMED);
  assign partial_clr = r_partial;
  assign clr_count   = r_clr_count;

endmodule

// File: tb/tb_bt_rnd_bank.sv
// Bench for bt_rnd_bank: directed scenarios plus randomized traffic against a behavioural model.
module tb_bt_rnd_bank;

  localparam int unsigned NB = 40;
  localparam int unsigned RW = 4;
  localparam int unsigned NW = NB / RW;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] rnd_in;
  logic          rnd_valid;
  logic          rnd_ready;
  logic          clear;
  logic [NB-1:0] rnd_acc;
  logic [NB-1:0] fresh_clear;
  logic          armed;
  logic [3:0]    fill_cnt;
  logic          partial_clr;
  logic [15:0]   clr_count;

  int total = 0;
  int bad   = 0;

  bt_rnd_bank #(.N_BITS(NB), .RND_W(RW)) dut (
    .clk         (clk),
    .rst         (rst),
    .rnd_in      (rnd_in),
    .rnd_valid   (rnd_valid),
    .rnd_ready   (rnd_ready),
    .clear       (clear),
    .rnd_acc     (rnd_acc),
    .fresh_clear (fresh_clear),
    .armed       (armed),
    .fill_cnt    (fill_cnt),
    .partial_clr (partial_clr),
    .clr_count   (clr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: word count, accumulated value, clear history and counters.
  bit          m_valid = 0;
  int          m_cnt;
  logic [63:0] m_acc;
  bit          m_prev_clr;
  int          m_clrs;
  bit          m_partial;

  always @(negedge clk) begin
    bit          pulse, rdy;
    logic [63:0] fmask;
    if (rst) begin
      m_valid    = 1;
      m_cnt      = 0;
      m_acc      = 0;
      m_prev_clr = 1;
      m_clrs     = 0;
      m_partial  = 0;
    end else if (m_valid) begin
      pulse = clear && !m_prev_clr;
      rdy   = (m_cnt < NW) && !pulse;
      fmask = pulse ? ((64'd1 << (m_cnt * RW)) - 64'd1) : 64'd0;
      chk("m_ready",   {63'd0, rnd_ready},   {63'd0, rdy});
      chk("m_fresh",   64'(fresh_clear),     fmask & ((64'd1 << NB) - 64'd1));
      chk("m_armed",   {63'd0, armed},       {63'd0, m_cnt == NW});
      chk("m_cnt",     64'(fill_cnt),        64'(m_cnt));
      chk("m_acc",     64'(rnd_acc),         m_acc);
      chk("m_partial", {63'd0, partial_clr}, {63'd0, m_partial});
      chk("m_clrs",    64'(clr_count),       64'(m_clrs % 65536));
      if (pulse) begin
        if (m_cnt != NW) m_partial = 1;
        m_cnt = 0;
        m_clrs++;
      end else if (rnd_valid && rdy) begin
        m_acc = ((m_acc << RW) | 64'(rnd_in)) & ((64'd1 << NB) - 64'd1);
        m_cnt++;
      end
      m_prev_clr = clear;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [RW-1:0] v);
    rnd_valid = 1'b1;
    rnd_in    = v;
    tick();
    rnd_valid = 1'b0;
  endtask

  task automatic push_seq(input int n);
    for (int k = 1; k <= n; k++) push(RW'(k));
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; rnd_valid = 1'b0; rnd_in = '0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_cnt",     64'(fill_cnt),    64'd0);
    chk("rst_acc",     64'(rnd_acc),     64'd0);
    chk("rst_armed",   64'(armed),       64'd0);
    chk("rst_partial", 64'(partial_clr), 64'd0);
    chk("rst_clrs",    64'(clr_count),   64'd0);
    chk("rst_ready",   64'(rnd_ready),   64'd1);

    // Full fill, then an extra word must be refused.
    push_seq(10);
    chk("fill_acc",   64'(rnd_acc),  64'h123456789A);
    chk("model_acc",  m_acc,         64'h123456789A);
    chk("fill_cnt",   64'(fill_cnt), 64'd10);
    chk("fill_armed", 64'(armed),    64'd1);
    rnd_valid = 1'b1; rnd_in = 4'hF; #1;
    chk("full_ready", 64'(rnd_ready), 64'd0);
    tick();
    rnd_valid = 1'b0;
    chk("full_acc", 64'(rnd_acc), 64'h123456789A);

    // Clear while armed.
    clear = 1'b1; #1;
    chk("aclr_fresh", 64'(fresh_clear), 64'hFF_FFFF_FFFF);
    tick();
    chk("aclr_fresh0",  64'(fresh_clear), 64'd0);
    chk("aclr_cnt",     64'(fill_cnt),    64'd0);
    chk("aclr_clrs",    64'(clr_count),   64'd1);
    chk("aclr_partial", 64'(partial_clr), 64'd0);
    clear = 1'b0; tick();

    // Partial clear after three words.
    push_seq(3);
    clear = 1'b1; #1;
    chk("pclr_fresh", 64'(fresh_clear), 64'h0FFF);
    tick();
    chk("pclr_partial", 64'(partial_clr), 64'd1);
    clear = 1'b0;
    push_seq(10);
    chk("pclr_armed",  64'(armed),       64'd1);
    chk("pclr_sticky", 64'(partial_clr), 64'd1);

    // Handshake attempt in the pulse cycle.
    clear = 1'b1; rnd_valid = 1'b1; rnd_in = 4'h5; #1;
    chk("sim_ready", 64'(rnd_ready), 64'd0);
    tick();
    chk("sim_cnt",    64'(fill_cnt),  64'd0);
    chk("sim_acc",    64'(rnd_acc),   64'h123456789A);
    chk("sim_ready1", 64'(rnd_ready), 64'd1);
    tick();
    rnd_valid = 1'b0;
    chk("sim_cnt1", 64'(fill_cnt), 64'd1);
    chk("sim_acc1", 64'(rnd_acc),  64'h23456789A5);
    clear = 1'b0; tick();

    // Held clear counts once; clear held across reset counts never.
    clear = 1'b1;
    repeat (20) tick();
    chk("hold_clrs", 64'(clr_count), 64'd4);
    clear = 1'b0; tick();
    clear = 1'b1; rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("rsthold_clrs", 64'(clr_count), 64'd0);
    clear = 1'b0; tick();

    // Reset mid-fill.
    push_seq(5);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rmid_acc", 64'(rnd_acc),  64'd0);
    chk("rmid_cnt", 64'(fill_cnt), 64'd0);
    push_seq(10);
    chk("rmid_armed", 64'(armed), 64'd1);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      rnd_valid = ($urandom_range(0, 9) < 7);
      rnd_in    = RW'($urandom);
      if ($urandom_range(0, 11) == 0) clear = ~clear;
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; rnd_valid = 1'b0; clear = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
